// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame checker.
package parity_pkg;

    // Frame-level FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Parity mode encodings as seen on the mode input.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes effect before
// the increment, so clear and increment on the same edge yield 1.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] base;

    // Holds at the all-ones value instead of wrapping.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    assign base = clr ? '0 : cnt;

    // Count register: clear first, then saturating increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= inc ? sat_inc(base) : base;
        end
    end

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming per-beat parity checker with per-frame verdict, overrun
// detection for frames longer than MAX_BEATS, and a saturating bad-frame count.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_par,
    input  logic              s_last,
    input  logic              mode,
    input  logic              clear_cnt,
    output logic              beat_err,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              overrun,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS);

    state_t        state, state_n;
    logic [CW-1:0] beat_cnt, beat_cnt_n;
    logic          mode_q, mode_n;
    logic          frame_err, frame_err_n;
    logic          ovr, ovr_n;

    logic          accept;
    logic          beat_par;
    logic          beat_fail;
    logic          last_acc;
    logic          ready_n;
    logic          beat_err_n;
    logic          frame_ok_n;
    logic          overrun_n;
    logic          frame_bad;

    assign accept   = s_valid && s_ready;
    assign beat_par = ^s_data ^ s_par;
    // The first beat of a frame is judged against the live mode input,
    // since that is the value being latched on the same edge.
    assign beat_fail = beat_par != ((state == IDLE) ? mode : mode_q);

    // Next-state, frame bookkeeping and registered-output values.
    always_comb begin
        state_n     = state;
        beat_cnt_n  = beat_cnt;
        mode_n      = mode_q;
        frame_err_n = frame_err;
        ovr_n       = ovr;
        beat_err_n  = 1'b0;
        last_acc    = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    mode_n      = mode;
                    beat_cnt_n  = CW'(1);
                    frame_err_n = beat_fail;
                    ovr_n       = 1'b0;
                    beat_err_n  = beat_fail;
                    if (s_last) begin
                        state_n  = REPORT;
                        last_acc = 1'b1;
                    end else if (MAX_BEATS == 1) begin
                        ovr_n   = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        state_n = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (accept) begin
                    beat_cnt_n  = beat_cnt + CW'(1);
                    frame_err_n = frame_err | beat_fail;
                    beat_err_n  = beat_fail;
                    if (s_last) begin
                        state_n  = REPORT;
                        last_acc = 1'b1;
                    end else if (beat_cnt_n == LAST_CNT) begin
                        ovr_n   = 1'b1;
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_n  = REPORT;
                    last_acc = 1'b1;
                end
            end
            REPORT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n    = (state_n != REPORT);
        frame_ok_n = last_acc && !frame_err_n && !ovr_n;
        overrun_n  = last_acc && ovr_n;
        frame_bad  = last_acc && !frame_ok_n;
    end

    // State, frame context and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            mode_q     <= PAR_EVEN;
            frame_err  <= 1'b0;
            ovr        <= 1'b0;
            s_ready    <= 1'b0;
            beat_err   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            overrun    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_n;
            beat_cnt   <= beat_cnt_n;
            mode_q     <= mode_n;
            frame_err  <= frame_err_n;
            ovr        <= ovr_n;
            s_ready    <= ready_n;
            beat_err   <= beat_err_n;
            frame_done <= last_acc;
            frame_ok   <= frame_ok_n;
            overrun    <= overrun_n;
            err_sticky <= (err_sticky && !clear_cnt) || frame_bad;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clear_cnt),
        .inc(frame_bad),
        .cnt(err_cnt)
    );

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Streaming parity checker for multi-beat frames of DATA_W-bit words. Each beat carries a parity bit. The block checks every beat against an even/odd mode that is latched per frame. It reports a per-frame verdict, flags frames longer than MAX_BEATS, and keeps a saturating count of bad frames. It sits on a valid/ready stream in front of the frame consumer. It replaces the single-word, always-ready 3-bit checker.

Parameters:
DATA_W, 8, width of s_data (>=1)
MAX_BEATS, 16, maximum legal beats per frame (>=1)
CNT_W, 16, width of err_cnt

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_valid  in  1  beat valid
s_ready  out  1  block can accept a beat
s_data  in  DATA_W  beat payload
s_par  in  1  parity bit sent with the beat
s_last  in  1  final beat of the frame
mode  in  1  0 = even parity, 1 = odd parity; sampled on the first beat of a frame
clear_cnt  in  1  synchronous clear of err_cnt and err_sticky
beat_err  out  1  one-cycle pulse, the previous accepted beat failed parity
frame_done  out  1  one-cycle pulse, frame verdict valid
frame_ok  out  1  verdict, valid while frame_done=1
overrun  out  1  frame exceeded MAX_BEATS, valid while frame_done=1
err_cnt  out  CNT_W  number of failed frames, saturating
err_sticky  out  1  set by any failed frame until clear_cnt

Behaviour:
- Reset (async): FSM=IDLE, beat counter=0, latched mode=0, and all outputs 0.
  - s_ready drives 1 from the first cycle after rst deasserts.
- Accept condition: s_valid && s_ready.
- Beat check: p = ^s_data ^ s_par.
  - Beat passes if p == latched mode: even mode needs p=0, odd mode needs p=1.
- beat_err: registered, high for one cycle after a failing beat is accepted in IDLE or ACTIVE. It is never raised in DRAIN.
- FSM state IDLE (s_ready=1), on accept:
  - latch mode, beat_cnt=1, frame_err = fail of this beat;
  - s_last=1 -> REPORT;
  - else if MAX_BEATS=1 -> set ovr, go to DRAIN;
  - else -> ACTIVE.
- FSM state ACTIVE (s_ready=1), on accept:
  - beat_cnt++, frame_err |= fail;
  - s_last=1 -> REPORT;
  - else if the beat just accepted is beat number MAX_BEATS -> set ovr, go to DRAIN.
  - A beat with s_last=1 at beat number MAX_BEATS is legal and goes to REPORT.
- FSM state DRAIN (s_ready=1): accepted beats are discarded without checking; the beat with s_last=1 -> REPORT.
- FSM state REPORT (s_ready=0): lasts exactly 1 cycle, then IDLE.
- On the edge that accepts the last beat, all of the following are registered together:
  - frame_done=1;
  - frame_ok = !frame_err && !ovr;
  - overrun = ovr;
  - if !frame_ok: err_cnt increments (holds at 2^CNT_W-1) and err_sticky=1.
  - frame_done is therefore high exactly during REPORT, one cycle after the last beat is accepted.
- frame_ok and overrun are 0 whenever frame_done=0.
- mode changes inside a frame are ignored until the next IDLE accept.
- clear_cnt: zeroes err_cnt and err_sticky. If it coincides with a failing-frame update, the clear applies first, giving err_cnt=1 and err_sticky=1.
- Reset mid-frame: the partial frame is discarded with no frame_done. The next beat starts a fresh frame.
- beat_cnt width: $clog2(MAX_BEATS+1); it never wraps, because the FSM leaves ACTIVE at MAX_BEATS.

Decomposition:
- Package parity_pkg holds:
  - typedef for the FSM state enum (IDLE, ACTIVE, DRAIN, REPORT);
  - constants PAR_EVEN=1'b0 and PAR_ODD=1'b1.
- Sub-module sat_counter (parameter W; inputs inc and clr; clr-then-inc semantics; output cnt) provides err_cnt.
- Beat parity is a single reduction expression; it needs no sub-module.

Test Plan:
All scenarios use DATA_W=8, MAX_BEATS=4, CNT_W=2.
- Even-mode good frame: beats (0x03,par0), (0x01,par1), (0xFF,par0,last) back-to-back -> no beat_err; frame_done=1 and frame_ok=1 the cycle after beat 3; s_ready=0 that cycle; err_cnt=0.
- Odd-mode single bad beat: mode=1, (0x00,par0,last) -> beat_err pulse; frame_ok=0, overrun=0; err_cnt=1; err_sticky=1.
- Overrun: 6 good even beats, last on beat 6 -> after beat 4 FSM enters DRAIN and beats 5-6 are accepted unchecked; frame_done after beat 6 with frame_ok=0, overrun=1. A 4-beat frame with last on beat 4 gives frame_ok=1.
- Mode latching: mode=0 on beat 1, mode=1 during beats 2-3, all beats even-correct -> frame_ok=1.
- Reset mid-frame: assert rst after 2 accepted beats -> all outputs 0 with no frame_done. A following 1-beat good frame -> frame_ok=1.
- Counter saturation and clear: 4 bad frames -> err_cnt=3 (held). Then a bad frame with clear_cnt asserted on its last-beat edge -> err_cnt=1, err_sticky=1. clear_cnt alone -> err_cnt=0, err_sticky=0.
